// File: rtl/spi_register_bank_if.sv
// Byte-stream and register-file bus between the SPI peripheral / FPGA fabric and spi_register_bank.
interface spi_register_bank_if #(
   parameter int unsigned ADDR_WIDTH = 4
);
   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   logic                      i_rx_dv;
   logic [7:0]                i_rx_byte;
   logic                      i_spi_cs_n;
   logic                      o_tx_dv;
   logic [7:0]                o_tx_byte;
   logic                      o_wr_strobe;
   logic [ADDR_WIDTH-1:0]     o_wr_addr;
   logic [7:0]                o_wr_data;
   logic [NUM_REGS*8-1:0]     o_regs;
   logic                      o_busy;

   modport master (
      output i_rx_dv, i_rx_byte, i_spi_cs_n,
      input  o_tx_dv, o_tx_byte, o_wr_strobe, o_wr_addr, o_wr_data, o_regs, o_busy
   );

   modport slave (
      input  i_rx_dv, i_rx_byte, i_spi_cs_n,
      output o_tx_dv, o_tx_byte, o_wr_strobe, o_wr_addr, o_wr_data, o_regs, o_busy
   );
endinterface

// File: rtl/spi_register_bank.sv
// SPI command decoder and register file: read/write bursts framed by a synchronised chip select.
// Optional macro SPI_REGS_WRITE_ECHO_EN echoes each written byte back on the next tx load.
module spi_register_bank #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter logic [7:0]  STATUS_BYTE = 8'hA5,
   parameter logic [7:0]  RESET_VALUE = 8'h00
) (
   input logic               i_clk,
   input logic               i_reset,
   spi_register_bank_if.slave bus
);
   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StCmd, StRead, StWrite} state_e;

   state_e                state_q, state_d;
   logic                  cs_meta_q, cs_s_q, cs_s_dly_q;
   logic                  cs_fall, cs_rise;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, cmd_addr;
   logic [7:0]            regs_q [NUM_REGS];
   logic                  wr_en;
   logic                  tx_dv_q, tx_dv_d;
   logic [7:0]            tx_byte_q, tx_byte_d;
   logic                  wr_strobe_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [7:0]            wr_data_q;
   logic                  busy_q;

   // Synchroniser idles high so reset never looks like a chip-select edge.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cs_meta_q  <= 1'b1;
         cs_s_q     <= 1'b1;
         cs_s_dly_q <= 1'b1;
      end else begin
         cs_meta_q  <= bus.i_spi_cs_n;
         cs_s_q     <= cs_meta_q;
         cs_s_dly_q <= cs_s_q;
      end
   end

   assign cs_fall  = cs_s_dly_q & ~cs_s_q;
   assign cs_rise  = ~cs_s_dly_q & cs_s_q;
   assign cmd_addr = bus.i_rx_byte[ADDR_WIDTH-1:0];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (cs_fall) state_d = StCmd;
         StCmd:   if (bus.i_rx_dv) state_d = bus.i_rx_byte[7] ? StRead : StWrite;
         StRead,
         StWrite: state_d = state_q;
         default: state_d = StIdle;
      endcase
      if (cs_rise) state_d = StIdle;
   end

   always_comb begin
      addr_d    = addr_q;
      tx_dv_d   = 1'b0;
      tx_byte_d = tx_byte_q;
      wr_en     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = STATUS_BYTE;
            end
         end
         StCmd: begin
            if (bus.i_rx_dv) begin
               tx_dv_d = 1'b1;
               if (bus.i_rx_byte[7]) begin
                  tx_byte_d = regs_q[cmd_addr];
                  addr_d    = cmd_addr + ADDR_WIDTH'(1);
               end else begin
                  tx_byte_d = 8'h00;
                  addr_d    = cmd_addr;
               end
            end
         end
         StRead: begin
            if (bus.i_rx_dv) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = regs_q[addr_q];
               addr_d    = addr_q + ADDR_WIDTH'(1);
            end
         end
         StWrite: begin
            if (bus.i_rx_dv) begin
               wr_en     = 1'b1;
               tx_dv_d   = 1'b1;
`ifdef SPI_REGS_WRITE_ECHO_EN
               tx_byte_d = bus.i_rx_byte;
`else
               tx_byte_d = 8'h00;
`endif
               addr_d    = addr_q + ADDR_WIDTH'(1);
            end
         end
         default: addr_d = '0;
      endcase
      // A byte landing with the CS rise is still served above; only the address is dropped.
      if (cs_rise) addr_d = '0;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         addr_q      <= '0;
         tx_dv_q     <= 1'b0;
         tx_byte_q   <= 8'h00;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'h00;
         busy_q      <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
      end else begin
         addr_q      <= addr_d;
         tx_dv_q     <= tx_dv_d;
         tx_byte_q   <= tx_byte_d;
         wr_strobe_q <= wr_en;
         busy_q      <= (state_d != StIdle);
         if (wr_en) begin
            regs_q[addr_q] <= bus.i_rx_byte;
            wr_addr_q      <= addr_q;
            wr_data_q      <= bus.i_rx_byte;
         end
      end
   end

   always_comb begin
      bus.o_regs = '0;
      for (int i = 0; i < NUM_REGS; i++) bus.o_regs[8*i +: 8] = regs_q[i];
   end

   assign bus.o_tx_dv     = tx_dv_q;
   assign bus.o_tx_byte   = tx_byte_q;
   assign bus.o_wr_strobe = wr_strobe_q;
   assign bus.o_wr_addr   = wr_addr_q;
   assign bus.o_wr_data   = wr_data_q;
   assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_spi_register_bank.sv
// Directed bench for spi_register_bank: scoreboard queues of expected tx bytes and register writes.
module tb_spi_register_bank;
   localparam int unsigned AW = 4;
   localparam int unsigned NR = 16;

   logic i_clk = 1'b0;
   logic i_reset;
   always #5 i_clk = ~i_clk;

   spi_register_bank_if #(.ADDR_WIDTH(AW)) bus ();

   spi_register_bank #(
      .ADDR_WIDTH (AW),
      .STATUS_BYTE(8'hA5),
      .RESET_VALUE(8'h00)
   ) dut (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .bus    (bus)
   );

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          last_tx_cyc = -1;
   int          last_rx_cyc = -1;
   int          cs_t0 = 0;
   logic [7:0]  tx_q [$];
   logic [11:0] wr_q [$];
   logic [7:0]  exp_regs [NR];
   logic [7:0]  tx_exp;
   logic [11:0] wr_exp;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Scoreboard: every tx load and write strobe must match the head of its queue.
   always @(negedge i_clk) begin
      if (bus.o_tx_dv) begin
         last_tx_cyc = cyc;
         tests++;
         assert (tx_q.size() != 0) else begin
            fails++;
            $error("FAIL tx_unexpected got=%02h want=none", bus.o_tx_byte);
         end
         if (tx_q.size() != 0) begin
            tx_exp = tx_q.pop_front();
            tests++;
            assert (bus.o_tx_byte === tx_exp) else begin
               fails++;
               $error("FAIL tx_byte got=%02h want=%02h", bus.o_tx_byte, tx_exp);
            end
         end
      end
      if (bus.o_wr_strobe) begin
         tests++;
         assert (wr_q.size() != 0) else begin
            fails++;
            $error("FAIL wr_unexpected got=%h/%02h want=none", bus.o_wr_addr, bus.o_wr_data);
         end
         tests++;
         assert (cyc - last_rx_cyc === 1) else begin
            fails++;
            $error("FAIL wr_latency got=%0d want=1", cyc - last_rx_cyc);
         end
         if (wr_q.size() != 0) begin
            wr_exp = wr_q.pop_front();
            tests++;
            assert ({bus.o_wr_addr, bus.o_wr_data} === wr_exp) else begin
               fails++;
               $error("FAIL wr_data got=%h want=%h", {bus.o_wr_addr, bus.o_wr_data}, wr_exp);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++)
         check($sformatf("%s_reg%0d", tag, i), 32'(bus.o_regs[8*i +: 8]), 32'(exp_regs[i]));
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_tx_left"}, 32'(tx_q.size()), 32'd0);
      check({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
   endtask

   task automatic cs_assert();
      cs_t0 = cyc;
      bus.i_spi_cs_n = 1'b0;
      tx_q.push_back(8'hA5);
      tick(6);
   endtask

   task automatic cs_release();
      bus.i_spi_cs_n = 1'b1;
      tick(6);
   endtask

   task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
      wr_q.push_back({a, d});
      exp_regs[a] = d;
   endtask

   task automatic send(input logic [7:0] b, input logic exp_en, input logic [7:0] exp_tx);
      if (exp_en) tx_q.push_back(exp_tx);
      last_rx_cyc = cyc;
      bus.i_rx_dv   = 1'b1;
      bus.i_rx_byte = b;
      tick(1);
      bus.i_rx_dv   = 1'b0;
      tick(7);
   endtask

   function automatic logic [7:0] echo(input logic [7:0] b);
`ifdef SPI_REGS_WRITE_ECHO_EN
      return b;
`else
      return 8'h00 & b;
`endif
   endfunction

   initial begin
      i_reset        = 1'b1;
      bus.i_spi_cs_n = 1'b1;
      bus.i_rx_dv    = 1'b0;
      bus.i_rx_byte  = 8'h00;
      for (int i = 0; i < NR; i++) exp_regs[i] = 8'h00;
      tick(3);

      // 1: reset state, status byte on CS fall
      check_regs("rst");
      check("rst_tx_dv", 32'(bus.o_tx_dv), 32'd0);
      check("rst_tx_byte", 32'(bus.o_tx_byte), 32'd0);
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_wr_strobe", 32'(bus.o_wr_strobe), 32'd0);
      check("rst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
      check("rst_wr_data", 32'(bus.o_wr_data), 32'd0);
      i_reset = 1'b0;
      tick(3);
      cs_assert();
      check("cs_fall_latency_ok",
            32'((last_tx_cyc - cs_t0 >= 3) && (last_tx_cyc - cs_t0 <= 4)), 32'd1);
      check("busy_in_frame", 32'(bus.o_busy), 32'd1);

      // 2: write burst to reg3/reg4
      send(8'h03, 1'b1, 8'h00);
      push_wr(4'd3, 8'h11);
      send(8'h11, 1'b1, echo(8'h11));
      push_wr(4'd4, 8'h22);
      send(8'h22, 1'b1, echo(8'h22));
      cs_release();
      check_drained("wr34");
      check_regs("wr34");
      check("busy_after_wr34", 32'(bus.o_busy), 32'd0);

      // 3: preload 14,15,0 (write wraps), then read burst wrapping 15 -> 0
      cs_assert();
      send(8'h0E, 1'b1, 8'h00);
      push_wr(4'd14, 8'h5C);
      send(8'h5C, 1'b1, echo(8'h5C));
      push_wr(4'd15, 8'h7E);
      send(8'h7E, 1'b1, echo(8'h7E));
      push_wr(4'd0, 8'h01);
      send(8'h01, 1'b1, echo(8'h01));
      cs_release();
      check_drained("preload");
      check_regs("preload");
      cs_assert();
      send(8'h8E, 1'b1, 8'h5C);
      send(8'h00, 1'b1, 8'h7E);
      send(8'h00, 1'b1, 8'h01);
      send(8'h00, 1'b1, 8'h00);
      cs_release();
      check_drained("rd_wrap");

      // 4: write-response bytes depend on the echo build
      cs_assert();
      send(8'h02, 1'b1, 8'h00);
      push_wr(4'd2, 8'h99);
      send(8'h99, 1'b1, echo(8'h99));
      cs_release();
      check_drained("wr2");
      check_regs("wr2");

      // 5: bytes with CS high are ignored; command-only frame writes nothing
      send(8'h55, 1'b0, 8'h00);
      check("idle_busy", 32'(bus.o_busy), 32'd0);
      check_drained("idle_rx");
      cs_assert();
      send(8'h05, 1'b1, 8'h00);
      check("cmd_busy", 32'(bus.o_busy), 32'd1);
      cs_release();
      check("cmd_only_busy", 32'(bus.o_busy), 32'd0);
      check_drained("cmd_only");
      check_regs("cmd_only");

      // 6: reset in the middle of a write burst
      cs_assert();
      send(8'h05, 1'b1, 8'h00);
      push_wr(4'd5, 8'hAB);
      send(8'hAB, 1'b1, echo(8'hAB));
      check_regs("pre_rst");
      i_reset = 1'b1;
      bus.i_spi_cs_n = 1'b1;
      #1;
      for (int i = 0; i < NR; i++) exp_regs[i] = 8'h00;
      check_regs("mid_rst");
      check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
      check("mid_rst_tx_dv", 32'(bus.o_tx_dv), 32'd0);
      tick(2);
      i_reset = 1'b0;
      tick(3);
      send(8'h77, 1'b0, 8'h00);
      send(8'h12, 1'b0, 8'h00);
      check_drained("post_rst");
      check_regs("post_rst");
      check("post_rst_busy", 32'(bus.o_busy), 32'd0);
      cs_assert();
      send(8'h85, 1'b1, 8'h00);
      send(8'h00, 1'b1, 8'h00);
      cs_release();
      check_drained("rd_after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end
endmodule
